// File: rtl/vx_mem_init_ctrl.sv
`timescale 1ns/1ps
// vx_mem_init_ctrl
// Bring-up sequencer that owns the memory port in front of Vortex. It holds
// Vortex in reset, streams a program image into memory as full-line writes,
// releases Vortex and then passes its request/response traffic straight
// through. In-flight reads are capped, and the run ends on completion or on
// a cycle limit.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   one-cycle pulse, honoured in IDLE and DONE only
//   image_base, image_len   first line address and length (lines) of the image
//   ld_valid/ld_ready/ld_data   loader stream of image lines
//   vx_reset                registered active-high reset to Vortex
//   vx_busy                 Vortex busy indication
//   vx_req_*, vx_rsp_*      Vortex memory request/response ports
//   mem_req_*, mem_rsp_*    memory-model request/response ports
//   done, timeout, cycles   registered run status and RUN-phase cycle count
//   state                   current sequencer state
module vx_mem_init_ctrl #(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT         = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   image_base,
    input  logic [ADDR_WIDTH-1:0]   image_len,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    output logic                    vx_reset,
    input  logic                    vx_busy,
    input  logic                    vx_req_valid,
    input  logic                    vx_req_rw,
    output logic                    vx_req_ready,
    input  logic [DATA_WIDTH/8-1:0] vx_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   vx_req_addr,
    input  logic [DATA_WIDTH-1:0]   vx_req_data,
    input  logic [TAG_WIDTH-1:0]    vx_req_tag,
    output logic                    vx_rsp_valid,
    input  logic                    vx_rsp_ready,
    output logic [DATA_WIDTH-1:0]   vx_rsp_data,
    output logic [TAG_WIDTH-1:0]    vx_rsp_tag,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    output logic                    mem_rsp_ready,
    output logic                    done,
    output logic                    timeout,
    output logic [31:0]             cycles,
    output logic [2:0]              state
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, len_q, idx_q;
    logic [CNT_W-1:0]      out_q;
    logic [31:0]           cycles_q;
    logic                  seen_busy_q, vx_reset_q, done_q, timeout_q;

    logic load_beat, rd_acc, rsp_acc, stall, complete, expire;

    assign state    = state_q;
    assign vx_reset = vx_reset_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

    // Only reads occupy a slot; writes never return a response.
    assign stall    = (out_q == CNT_W'(MAX_OUTSTANDING)) && !vx_req_rw;
    assign complete = seen_busy_q && !vx_busy && (out_q == '0);
    assign expire   = (cycles_q == 32'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        ld_ready       = 1'b0;
        vx_req_ready   = 1'b0;
        vx_rsp_valid   = 1'b0;
        vx_rsp_data    = '0;
        vx_rsp_tag     = '0;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr   = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
        mem_rsp_ready  = 1'b0;
        load_beat      = 1'b0;
        rd_acc         = 1'b0;
        rsp_acc        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = (image_len != '0) ? S_LOAD : S_RELEASE;
            end
            S_LOAD: begin
                mem_req_valid  = ld_valid;
                ld_ready       = mem_req_ready;
                mem_req_rw     = 1'b1;
                mem_req_byteen = '1;
                mem_req_addr   = base_q + idx_q;
                mem_req_data   = ld_data;
                load_beat      = ld_valid && mem_req_ready;
                if (load_beat && (idx_q == len_q - ADDR_WIDTH'(1))) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_RUN;
            S_RUN: begin
                mem_req_valid  = vx_req_valid && !stall;
                vx_req_ready   = mem_req_ready && !stall;
                mem_req_rw     = vx_req_rw;
                mem_req_byteen = vx_req_byteen;
                mem_req_addr   = vx_req_addr;
                mem_req_data   = vx_req_data;
                mem_req_tag    = vx_req_tag;
                vx_rsp_valid   = mem_rsp_valid;
                vx_rsp_data    = mem_rsp_data;
                vx_rsp_tag     = mem_rsp_tag;
                mem_rsp_ready  = vx_rsp_ready;
                rd_acc         = vx_req_valid && mem_req_ready && !stall && !vx_req_rw;
                rsp_acc        = mem_rsp_valid && vx_rsp_ready;
                if (complete || expire) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            cycles_q    <= '0;
            seen_busy_q <= 1'b0;
            vx_reset_q  <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            state_q    <= state_d;
            // Registered from the next state so the fall lines up with RUN entry.
            vx_reset_q <= (state_d != S_RUN);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_q    <= image_base;
                        len_q     <= image_len;
                        idx_q     <= '0;
                        out_q     <= '0;
                        cycles_q  <= '0;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_beat) idx_q <= idx_q + ADDR_WIDTH'(1);
                end
                S_RELEASE: seen_busy_q <= 1'b0;
                S_RUN: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
                    if (vx_busy) seen_busy_q <= 1'b1;
                    // Simultaneous issue and return cancel; a stray response
                    // at zero must not wrap the count.
                    if (rd_acc && !rsp_acc) out_q <= out_q + CNT_W'(1);
                    else if (rsp_acc && !rd_acc && (out_q != '0)) out_q <= out_q - CNT_W'(1);
                    if (state_d == S_DONE) begin
                        done_q    <= 1'b1;
                        timeout_q <= !complete;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_mem_init_ctrl.sv
`timescale 1ns/1ps
module tb_vx_mem_init_ctrl;

    localparam int AW = 26, DW = 64, TW = 8, MAXO = 4, TMO = 100;

    logic clk = 1'b0, reset_n = 1'b0, start;
    logic [AW-1:0] image_base, image_len;
    logic ld_valid, ld_ready;
    logic [DW-1:0] ld_data;
    logic vx_reset, vx_busy;
    logic vx_req_valid, vx_req_rw, vx_req_ready;
    logic [DW/8-1:0] vx_req_byteen;
    logic [AW-1:0] vx_req_addr;
    logic [DW-1:0] vx_req_data;
    logic [TW-1:0] vx_req_tag;
    logic vx_rsp_valid, vx_rsp_ready;
    logic [DW-1:0] vx_rsp_data;
    logic [TW-1:0] vx_rsp_tag;
    logic mem_req_valid, mem_req_rw, mem_req_ready;
    logic [DW/8-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic done, timeout;
    logic [31:0] cycles;
    logic [2:0] state;

    vx_mem_init_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .image_base(image_base), .image_len(image_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .vx_reset(vx_reset), .vx_busy(vx_busy),
        .vx_req_valid(vx_req_valid), .vx_req_rw(vx_req_rw), .vx_req_ready(vx_req_ready),
        .vx_req_byteen(vx_req_byteen), .vx_req_addr(vx_req_addr),
        .vx_req_data(vx_req_data), .vx_req_tag(vx_req_tag),
        .vx_rsp_valid(vx_rsp_valid), .vx_rsp_ready(vx_rsp_ready),
        .vx_rsp_data(vx_rsp_data), .vx_rsp_tag(vx_rsp_tag),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .done(done), .timeout(timeout), .cycles(cycles), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ST_IDLE = 0, ST_LOAD = 1, ST_REL = 2, ST_RUN = 3, ST_DONE = 4;

    int n_checks = 0, n_pass = 0;
    logic [DW-1:0] image [0:15];
    logic [TW-1:0] pending [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; ld_valid = 0; ld_data = '0; vx_busy = 0;
        vx_req_valid = 0; vx_req_rw = 0; vx_req_byteen = '0; vx_req_addr = '0;
        vx_req_data = '0; vx_req_tag = '0; vx_rsp_ready = 0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_tag = '0;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] len);
        for (int i = 0; i < 16; i++) image[i] = {$urandom, $urandom};
        start = 1; image_base = base; image_len = len;
        to_sample();
        to_drive();
        start = 0; image_base = AW'($urandom); image_len = AW'($urandom);
    endtask

    // mode 0: loader and memory always ready; 1: memory ready toggles; 2: both random.
    task automatic load_phase(input logic [AW-1:0] base, input int len, input int mode);
        int ei = 0, ncyc = 0;
        logic [AW-1:0] ea;
        for (int k = 0; k < 200 && ei < len; k++) begin
            ld_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data = image[ei];
            mem_req_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(k % 2 == 0) : 1'($urandom_range(0, 1));
            start = (mode == 2) && ($urandom_range(0, 7) == 0);
            to_sample();
            ea = base + AW'(ei);
            check("ld_state", state, ST_LOAD);
            check("ld_vx_reset", vx_reset, 1);
            check("ld_vx_req_ready", vx_req_ready, 0);
            check("ld_vx_rsp_valid", vx_rsp_valid, 0);
            check("ld_valid_pass", mem_req_valid, ld_valid);
            check("ld_ready_pass", ld_ready, mem_req_ready);
            if (ld_valid) begin
                check("ld_addr", mem_req_addr, ea);
                check("ld_data", mem_req_data, image[ei]);
                check("ld_rw", mem_req_rw, 1);
                check("ld_byteen", mem_req_byteen, 64'hff);
                check("ld_tag", mem_req_tag, 0);
            end
            if (ld_valid && mem_req_ready) ei++;
            ncyc++;
            to_drive();
        end
        check("ld_beats", ei, len);
        if (mode == 0) check("ld_consecutive", ncyc, len);
        start = 0;
    endtask

    task automatic release_check();
        ld_valid = 1; mem_req_ready = 1;
        to_sample();
        check("rel_state", state, ST_REL);
        check("rel_vx_reset", vx_reset, 1);
        check("rel_ld_ready", ld_ready, 0);
        check("rel_mem_valid", mem_req_valid, 0);
        to_drive();
        idle_inputs();
    endtask

    // Reference: cycle count, busy-seen flag and outstanding-read count kept
    // as plain integers from the handshakes the bench itself drives.
    task automatic run_phase(input int busy_cycles, input bit traffic, output int run_n, output bit got_to);
        int ref_cycles = 0, ref_out = 0;
        bit ref_seen = 0, fin = 0, stall, rd, rs, cmpl, expire;
        run_n = 0; got_to = 0;
        pending.delete();
        for (int k = 0; k < 300 && !fin; k++) begin
            vx_busy = (k < busy_cycles);
            start = traffic && ($urandom_range(0, 7) == 0);
            image_len = AW'($urandom_range(1, 9));
            vx_req_valid = traffic && vx_busy && 1'($urandom_range(0, 1));
            vx_req_rw = 1'($urandom_range(0, 1));
            vx_req_byteen = 8'($urandom); vx_req_addr = AW'($urandom);
            vx_req_data = {$urandom, $urandom}; vx_req_tag = TW'($urandom);
            mem_req_ready = traffic ? ($urandom_range(0, 3) != 0) : 1'b1;
            vx_rsp_ready = traffic ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pending.size() > 0) begin
                mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_tag = pending[0];
            end else begin
                mem_rsp_valid = traffic && ($urandom_range(0, 7) == 0); mem_rsp_tag = TW'($urandom);
            end
            mem_rsp_data = {$urandom, $urandom};
            to_sample();
            stall = (ref_out == MAXO) && !vx_req_rw;
            check("run_state", state, ST_RUN);
            check("run_vx_reset", vx_reset, 0);
            check("run_done", done, 0);
            check("run_cycles", cycles, ref_cycles);
            check("run_req_valid", mem_req_valid, vx_req_valid && !stall);
            check("run_req_ready", vx_req_ready, mem_req_ready && !stall);
            check("run_req_rw", mem_req_rw, vx_req_rw);
            check("run_req_byteen", mem_req_byteen, vx_req_byteen);
            check("run_req_addr", mem_req_addr, vx_req_addr);
            check("run_req_data", mem_req_data, vx_req_data);
            check("run_req_tag", mem_req_tag, vx_req_tag);
            check("run_rsp_valid", vx_rsp_valid, mem_rsp_valid);
            check("run_rsp_ready", mem_rsp_ready, vx_rsp_ready);
            check("run_rsp_data", vx_rsp_data, mem_rsp_data);
            check("run_rsp_tag", vx_rsp_tag, mem_rsp_tag);
            rd = vx_req_valid && mem_req_ready && !stall && !vx_req_rw;
            rs = mem_rsp_valid && vx_rsp_ready;
            cmpl = ref_seen && !vx_busy && (ref_out == 0);
            expire = (ref_cycles == TMO - 1);
            if (rd) pending.push_back(vx_req_tag);
            if (rs && pending.size() > 0) void'(pending.pop_front());
            if (rd && !rs) ref_out++;
            else if (rs && !rd && ref_out > 0) ref_out--;
            ref_seen |= vx_busy;
            ref_cycles++;
            run_n++;
            if (cmpl || expire) begin
                fin = 1; got_to = !cmpl;
            end
            to_drive();
        end
        check("run_ended", fin, 1);
        idle_inputs();
        to_sample();
        check("done_state", state, ST_DONE);
        check("done_flag", done, 1);
        check("done_timeout", timeout, got_to);
        check("done_cycles", cycles, ref_cycles);
        check("done_vx_reset", vx_reset, 1);
        check("done_mem_valid", mem_req_valid, 0);
        to_drive();
    endtask

    task automatic cap_test();
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            vx_busy = 1; vx_req_valid = 1; vx_req_rw = 0; vx_req_tag = TW'(i);
            mem_req_ready = 1; vx_rsp_ready = 1; mem_rsp_valid = 0;
            to_sample();
            if (vx_req_ready && mem_req_valid) acc++;
            to_drive();
        end
        check("cap_reads_accepted", acc, MAXO);
        vx_req_rw = 1;
        to_sample();
        check("cap_write_ready", vx_req_ready, 1);
        check("cap_write_valid", mem_req_valid, 1);
        to_drive();
        vx_req_rw = 0;
        to_sample();
        check("cap_read_stalled", vx_req_ready, 0);
        check("cap_read_valid", mem_req_valid, 0);
        to_drive();
        vx_req_valid = 0; mem_rsp_valid = 1; mem_rsp_tag = 0;
        to_sample();
        check("cap_rsp_valid", vx_rsp_valid, 1);
        to_drive();
        mem_rsp_valid = 0; vx_req_valid = 1;
        to_sample();
        check("cap_fifth_read", vx_req_ready, 1);
        to_drive();
        to_sample();
        check("cap_full_again", vx_req_ready, 0);
    endtask

    // Called on a falling edge: reset asserts between clock edges.
    task automatic async_reset_check(input string tag);
        #1 reset_n = 0;
        #1;
        check({tag, "_state"}, state, ST_IDLE);
        check({tag, "_vx_reset"}, vx_reset, 1);
        check({tag, "_mem_valid"}, mem_req_valid, 0);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_vx_req_ready"}, vx_req_ready, 0);
        check({tag, "_mem_rsp_ready"}, mem_rsp_ready, 0);
        check({tag, "_cycles"}, cycles, 0);
        #1 reset_n = 1;
        idle_inputs();
        to_drive();
    endtask

    initial begin
        int rn;
        bit to;
        logic [AW-1:0] base;
        idle_inputs();
        image_base = '0; image_len = '0;
        to_sample();
        to_sample();
        check("rst_state", state, ST_IDLE);
        check("rst_vx_reset", vx_reset, 1);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycles", cycles, 0);
        #1 reset_n = 1;
        to_drive();

        // Straight load, then outstanding-read cap, then reset mid-RUN.
        do_start(26'h100, 26'd4);
        load_phase(26'h100, 4, 0);
        release_check();
        cap_test();
        async_reset_check("rst_run");

        // Zero-length image, completion after 50 busy cycles.
        do_start(26'h0, 26'd0);
        release_check();
        run_phase(50, 0, rn, to);
        check("cmpl_run_cycles", rn, 51);

        // Backpressured load, then busy forever until the cycle limit.
        base = AW'($urandom);
        do_start(base, 26'd6);
        load_phase(base, 6, 1);
        release_check();
        run_phase(1000, 0, rn, to);
        check("to_run_cycles", rn, TMO);
        check("to_flag", to, 1);

        // Randomized loads and traffic, one image wrapping the address space.
        for (int it = 0; it < 6; it++) begin
            int len = $urandom_range(1, 8);
            base = (it == 0) ? 26'h3fffffe : AW'($urandom);
            do_start(base, AW'(len));
            load_phase(base, len, 2);
            release_check();
            run_phase($urandom_range(5, 70), 1, rn, to);
        end

        // Reset while beat 2 of a load is on the port, then a zero-length run.
        base = 26'h2000;
        do_start(base, 26'd5);
        for (int b = 0; b < 2; b++) begin
            ld_valid = 1; mem_req_ready = 1; ld_data = image[b];
            to_drive();
        end
        ld_valid = 1; mem_req_ready = 1; ld_data = image[2];
        to_sample();
        check("mid_ld_beat2_valid", mem_req_valid, 1);
        check("mid_ld_beat2_addr", mem_req_addr, base + 26'd2);
        async_reset_check("rst_load");
        do_start(26'h40, 26'd0);
        release_check();
        run_phase(3, 0, rn, to);
        check("post_rst_run_cycles", rn, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vx_mem_init_ctrl.md
Name: vx_mem_init_ctrl

Overview:
- Bring-up sequencer and memory-port owner for the Vortex + bypass-RAM testbench.
- Holds Vortex in reset, streams a program image into memory as line writes, then releases Vortex and passes its traffic through to memory.
- Tracks outstanding reads and detects run completion or timeout.
- Sits between Vortex's mem_req/mem_rsp ports and the memory model.

Parameters:
- ADDR_WIDTH, 26, line-address width.
- DATA_WIDTH, 512, line width in bits.
- TAG_WIDTH, 8, request/response tag width.
- MAX_OUTSTANDING, 16, cap on in-flight reads; power of two.
- TIMEOUT, 1000000, RUN-phase cycle limit; must be at least 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load/run sequence
- image_base  in  ADDR_WIDTH  first line address of the image
- image_len  in  ADDR_WIDTH  image length in lines
- ld_valid / ld_ready  in / out  1  loader stream handshake
- ld_data  in  DATA_WIDTH  image line
- vx_reset  out  1  reset to Vortex, active-high
- vx_busy  in  1  Vortex busy
- vx_req_valid, vx_req_rw / vx_req_ready  in / out  1  Vortex request handshake
- vx_req_byteen  in  DATA_WIDTH/8  Vortex byte enables
- vx_req_addr  in  ADDR_WIDTH  Vortex request address
- vx_req_data  in  DATA_WIDTH  Vortex write data
- vx_req_tag  in  TAG_WIDTH  Vortex request tag
- vx_rsp_valid / vx_rsp_ready  out / in  1  Vortex response handshake
- vx_rsp_data, vx_rsp_tag  out  DATA_WIDTH, TAG_WIDTH  Vortex response payload
- mem_req_valid, mem_req_rw  out  1  memory request
- mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag  out  widths as on Vortex side
- mem_req_ready  in  1  memory request ready
- mem_rsp_valid, mem_rsp_data, mem_rsp_tag  in  memory response
- mem_rsp_ready  out  1  memory response ready
- done  out  1  sequence finished
- timeout  out  1  sequence ended by timeout
- cycles  out  32  RUN-phase cycle count
- state  out  3  current FSM state

Behaviour:
Reset (reset_n low, asynchronous):
- state=IDLE, vx_reset=1, all valid/ready outputs 0, done=0, timeout=0, cycles=0.
- Outstanding count and line index cleared.
- Effective immediately, including mid-LOAD or mid-RUN; in-flight memory responses afterwards are dropped.

IDLE:
- vx_reset=1.
- start latches image_base/image_len, clears done, timeout and cycles.
- Goes to LOAD if image_len!=0, else RELEASE.

LOAD:
- Memory port owned by the loader; Vortex ports held at ready=0, valid=0.
- mem_req_valid=ld_valid, ld_ready=mem_req_ready.
- Request fields: rw=1, byteen all ones, addr=image_base+idx (ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH), data=ld_data, tag=0.
- idx increments on each accepted beat; after beat image_len-1 is accepted, go to RELEASE.
- Writes return no response.

RELEASE:
- One cycle with vx_reset=1, then RUN.
- vx_reset is registered and falls on RUN entry.

RUN, combinational pass-through of Vortex requests:
- mem_req_* = vx_req_*.
- mem_req_valid = vx_req_valid & !stall; vx_req_ready = mem_req_ready & !stall.
- stall = (outstanding==MAX_OUTSTANDING) & !vx_req_rw; writes never stall.

RUN, outstanding read tracking:
- Count +1 on accepted read request, -1 on accepted response (vx_rsp_valid & vx_rsp_ready).
- Both in the same cycle: count unchanged.
- A response arriving at count 0 leaves the count at 0 (no underflow).

RUN, responses:
- vx_rsp_* = mem_rsp_*, mem_rsp_ready = vx_rsp_ready.

RUN, counting and exit:
- cycles increments every RUN cycle, saturating at 2^32-1.
- seen_busy is set when vx_busy is first 1.
- Completion: seen_busy & !vx_busy & outstanding==0 goes to DONE.
- If cycles reaches TIMEOUT-1 without completion: timeout=1, go to DONE. Completion wins if both occur in the same cycle.

DONE:
- vx_reset=1, done=1, memory port idle.
- start restarts the sequence as from IDLE.

General:
- start is ignored in LOAD, RELEASE and RUN.
- No combinational path from ld_valid to vx ports.
- All outputs not listed above as pass-through are registered.

Test Plan:
- Load/run: image_base=0x100, image_len=4, loader presents lines continuously with mem_req_ready=1 -> 4 writes to 0x100..0x103 in 4 consecutive cycles, ld_ready low afterwards. vx_reset is 1 throughout load plus one cycle, then falls.
- Backpressure: mem_req_ready toggles 1,0,1,0 during LOAD -> each beat is held stable until accepted; no address skipped or duplicated.
- Outstanding cap: MAX_OUTSTANDING=4, Vortex issues 6 reads, responses withheld -> exactly 4 accepted and vx_req_ready=0 for reads while writes still pass. After 1 response, a 5th read is accepted.
- Completion: vx_busy high for 50 cycles, then low with 0 outstanding -> done=1 one cycle later, timeout=0, cycles≈51.
- Timeout: TIMEOUT=100, vx_busy held high -> timeout=1 and done=1 after exactly 100 RUN cycles, vx_reset re-asserted.
- Async reset mid-LOAD at beat 2 -> all valids 0 and state=IDLE in the same cycle. A subsequent start with image_len=0 goes straight to RELEASE then RUN.
